hsv_to_rgb565: RTL
==================

// Module: hsv_to_rgb565
// PURPOSE
//  Pipelined HSV -> RGB565 colour converter; inverse of the RGB565 -> S/V/decision path in the camera/VGA chain.
//  Turns overlay/marker colours given in HSV (traffic-light red/green, UI highlights) into RGB565 for the VGA
//  frame path. Valid/ready stream in and out, 3-stage pipeline, global-stall backpressure, output-pixel counter.
// PARAMETERS
//  CNT_W      16   width of pix_cnt (wraps modulo 2**CNT_W)
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  reset_n    in   1      asynchronous active-low reset
//  in_valid   in   1      h/s/v_data valid this cycle
//  in_ready   out  1      converter accepts input this cycle
//  h_data     in   9      hue in degrees, nominal 0..359
//  s_data     in   8      saturation 0..255
//  v_data     in   8      value 0..255
//  out_valid  out  1      r/g/b_data valid
//  out_ready  in   1      downstream accepts output
//  r_data     out  5      red, RGB565
//  g_data     out  6      green, RGB565
//  b_data     out  5      blue, RGB565
//  pix_cnt    out  CNT_W  count of output transfers (out_valid & out_ready)
// BEHAVIOUR
//  Reset (async, reset_n=0): all stage valids=0, out_valid=0, r/g/b_data=0, pix_cnt=0; in_ready follows en.
//  Stall: en = out_ready | ~out_valid; in_ready = en (combinational). When en=1 all three stages shift together;
//   when en=0 every stage register holds. Bubbles are not collapsed. Input accepted iff in_valid & in_ready.
//  Latency: exactly 3 clk edges from acceptance to out_valid with out_ready held 1; throughput 1 pixel/clk.
//  Stage 1: hw = (h_data >= 360) ? h_data - 360 : h_data (360..511 wrap to 0..151);
//   sector = hw/60 (0..5, by compare chain), f = hw - 60*sector (0..59); register sector, f, s, v, valid.
//  Stage 2 (floor integer division, intermediates >= 17 bit, no overflow):
//   p = v*(255-s)/255; q = v*(255 - s*f/60)/255; t = v*(255 - s*(60-f)/60)/255.
//   Register p, q, t, v, sector, valid.
//  Stage 3: (R,G,B) by sector: 0:(v,t,p) 1:(q,v,p) 2:(p,v,t) 3:(p,q,v) 4:(t,p,v) 5:(v,p,q).
//   r_data=R[7:3], g_data=G[7:2], b_data=B[7:3] (truncation; exact inverse of {x, x[msbs]} 565->888 expansion).
//  s_data=0 falls out of formulas: p=q=t=v -> grey, independent of h.
//  Output hold: while out_valid=1 and out_ready=0, r/g/b_data and out_valid stay constant.
//  When out_valid=0, r/g/b_data hold last value (don't-care for checkers).
//  pix_cnt increments by 1 on each out_valid & out_ready cycle; wraps all-ones -> 0.
//  Simultaneous accept at input and transfer at output in same cycle is normal full-rate operation.
//  reset_n asserted mid-stream: in-flight pixels discarded, no partial output after release; first output after
//   reset is the first pixel accepted after reset_n deasserts.
// TESTING
//  h=0,s=255,v=255, ready=1 -> 3 clks later r=31,g=0,b=0, out_valid 1 cycle, pix_cnt=1.
//  h=120,s=255,v=255 -> r=0,g=63,b=0; h=30,s=255,v=255 -> r=31,g=32,b=0 (t=128).
//  h=200,s=0,v=128 -> r=16,g=32,b=16; h=420,s=255,v=255 -> same as h=60: r=31,g=63,b=0.
//  Stream 10 pixels, out_ready=0 for 5 clks mid-stream -> out_valid/data stable, in_ready=0 while stalled,
//   all 10 outputs appear in order, none lost/duplicated, pix_cnt=10.
//  Sweep h 0..511 step 1, s,v random, ready random -> output matches reference model bit-exactly.
//  reset_n pulse low with 3 pixels in flight -> outputs/pix_cnt=0 at once, no stale pixel after release.

Source files
------------

// File: rtl/hsv_to_rgb565_if.sv
// Stream bundle for the HSV -> RGB565 converter: an HSV input stream and an
// RGB565 output stream.
// Handshake: a beat transfers on a rising clk edge where valid & ready are both
// 1. A producer holds valid and its data stable until that transfer. Ready may
// depend combinationally on the consumer's state.
interface hsv_to_rgb565_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] h_data;
  logic [7:0] s_data;
  logic [7:0] v_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] r_data;
  logic [5:0] g_data;
  logic [4:0] b_data;

  // Converter side: consumes HSV and produces RGB565.
  modport slave (
    input  in_valid, h_data, s_data, v_data, out_ready,
    output in_ready, out_valid, r_data, g_data, b_data
  );

  // Environment side: produces HSV and consumes RGB565.
  modport master (
    output in_valid, h_data, s_data, v_data, out_ready,
    input  in_ready, out_valid, r_data, g_data, b_data
  );
endinterface

// File: rtl/hsv_to_rgb565.sv
// Three-stage pipelined HSV -> RGB565 converter with global-stall backpressure
// and a counter of completed output transfers.
module hsv_to_rgb565 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  hsv_to_rgb565_if.slave   bus,
  output logic [CNT_W-1:0] pix_cnt
);

  // Global enable: the whole pipe advances when the output slot is free or draining.
  logic w_en;

  // Stage 1 registers
  logic       r_s1_valid;
  logic [2:0] r_s1_sector;
  logic [5:0] r_s1_f;
  logic [7:0] r_s1_s;
  logic [7:0] r_s1_v;

  // Stage 2 registers
  logic       r_s2_valid;
  logic [2:0] r_s2_sector;
  logic [7:0] r_s2_p;
  logic [7:0] r_s2_q;
  logic [7:0] r_s2_t;
  logic [7:0] r_s2_v;

  // Stage 3 (output) registers
  logic             r_s3_valid;
  logic [4:0]       r_r;
  logic [5:0]       r_g;
  logic [4:0]       r_b;
  logic [CNT_W-1:0] r_pix_cnt;

  // Combinational stage results
  logic [8:0] w_hw;
  logic [8:0] w_base;
  logic [2:0] w_sector;
  logic [5:0] w_f;
  logic [7:0] w_p;
  logic [7:0] w_q;
  logic [7:0] w_t;
  logic [4:0] w_r;
  logic [5:0] w_g;
  logic [4:0] w_b;

  assign w_en         = bus.out_ready | ~r_s3_valid;
  assign bus.in_ready = w_en;
  assign bus.out_valid = r_s3_valid;
  assign bus.r_data   = r_r;
  assign bus.g_data   = r_g;
  assign bus.b_data   = r_b;
  assign pix_cnt      = r_pix_cnt;

  // Stage 1 logic: fold hue into 0..359, then find the 60-degree sector and offset.
  always_comb begin
    w_hw     = (bus.h_data >= 9'd360) ? (bus.h_data - 9'd360) : bus.h_data;
    w_sector = 3'd5;
    w_base   = 9'd300;
    if (w_hw < 9'd60) begin
      w_sector = 3'd0;
      w_base   = 9'd0;
    end else if (w_hw < 9'd120) begin
      w_sector = 3'd1;
      w_base   = 9'd60;
    end else if (w_hw < 9'd180) begin
      w_sector = 3'd2;
      w_base   = 9'd120;
    end else if (w_hw < 9'd240) begin
      w_sector = 3'd3;
      w_base   = 9'd180;
    end else if (w_hw < 9'd300) begin
      w_sector = 3'd4;
      w_base   = 9'd240;
    end
    w_f = 6'(w_hw - w_base);
  end

  // Stage 2 logic: p/q/t with floor division; 18-bit products cannot overflow (max 65025).
  always_comb begin
    w_p = 8'((18'(r_s1_v) * (18'd255 - 18'(r_s1_s))) / 18'd255);
    w_q = 8'((18'(r_s1_v) *
              (18'd255 - (18'(r_s1_s) * 18'(r_s1_f)) / 18'd60)) / 18'd255);
    w_t = 8'((18'(r_s1_v) *
              (18'd255 - (18'(r_s1_s) * (18'd60 - 18'(r_s1_f))) / 18'd60)) / 18'd255);
  end

  // Stage 3 logic: route p/q/t/v to R/G/B by sector and truncate to 5/6/5 bits.
  always_comb begin
    w_r = r_s2_v[7:3];
    w_g = r_s2_p[7:2];
    w_b = r_s2_q[7:3];
    case (r_s2_sector)
      3'd0: begin w_r = r_s2_v[7:3]; w_g = r_s2_t[7:2]; w_b = r_s2_p[7:3]; end
      3'd1: begin w_r = r_s2_q[7:3]; w_g = r_s2_v[7:2]; w_b = r_s2_p[7:3]; end
      3'd2: begin w_r = r_s2_p[7:3]; w_g = r_s2_v[7:2]; w_b = r_s2_t[7:3]; end
      3'd3: begin w_r = r_s2_p[7:3]; w_g = r_s2_q[7:2]; w_b = r_s2_v[7:3]; end
      3'd4: begin w_r = r_s2_t[7:3]; w_g = r_s2_p[7:2]; w_b = r_s2_v[7:3]; end
      default: begin w_r = r_s2_v[7:3]; w_g = r_s2_p[7:2]; w_b = r_s2_q[7:3]; end
    endcase
  end

  // Pipeline registers: all stages shift together on w_en, bubbles included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sector <= 3'd0;
      r_s1_f      <= 6'd0;
      r_s1_s      <= 8'd0;
      r_s1_v      <= 8'd0;
      r_s2_valid  <= 1'b0;
      r_s2_sector <= 3'd0;
      r_s2_p      <= 8'd0;
      r_s2_q      <= 8'd0;
      r_s2_t      <= 8'd0;
      r_s2_v      <= 8'd0;
      r_s3_valid  <= 1'b0;
      r_r         <= 5'd0;
      r_g         <= 6'd0;
      r_b         <= 5'd0;
    end else if (w_en) begin
      r_s1_valid  <= bus.in_valid;
      r_s1_sector <= w_sector;
      r_s1_f      <= w_f;
      r_s1_s      <= bus.s_data;
      r_s1_v      <= bus.v_data;
      r_s2_valid  <= r_s1_valid;
      r_s2_sector <= r_s1_sector;
      r_s2_p      <= w_p;
      r_s2_q      <= w_q;
      r_s2_t      <= w_t;
      r_s2_v      <= r_s1_v;
      r_s3_valid  <= r_s2_valid;
      r_r         <= w_r;
      r_g         <= w_g;
      r_b         <= w_b;
    end
  end

  // Output transfer counter, wraps naturally at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_cnt <= '0;
    end else if (r_s3_valid && bus.out_ready) begin
      r_pix_cnt <= r_pix_cnt + CNT_W'(1);
    end
  end

endmodule
